// File: rtl/subcarrier_integrator.sv
// subcarrier_integrator: integrates NUM_SC baseband I/Q streams over each
// frequency dwell and serialises the latched sums as a framed beat sequence
// (header, I window per channel, Q window per channel, record count).
// Optional feature macro: SUBCARRIER_INTEGRATOR_SATURATE_EN
//   defined   -> saturating accumulators and clamped output window
//   undefined -> two's-complement wrap and plain bit-slice window
module subcarrier_integrator #(
    parameter int unsigned NUM_SC    = 4,
    parameter int unsigned ACC_WIDTH = 36,
    parameter int unsigned OUT_SHIFT = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   record,
    input  logic                   freq_step,
    input  logic [16*NUM_SC-1:0]   bb_i,
    input  logic [16*NUM_SC-1:0]   bb_q,
    input  logic                   data_out_strobe,
    output logic                   out_valid,
    output logic [15:0]            i_out,
    output logic [15:0]            q_out,
    output logic                   overrun
);

    localparam int unsigned NBEATS = 2 * NUM_SC + 2;
    localparam int unsigned BW     = $clog2(NBEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    state_e                       state_q, state_d;
    logic [BW-1:0]                beat_q, beat_d;
    logic [7:0]                   seq_q, seq_d;
    logic [7:0]                   seq_lat_q, seq_lat_d;
    logic [15:0]                  rec_q, rec_d;
    logic [15:0]                  rec_lat_q, rec_lat_d;
    logic                         ovr_q, ovr_d;
    logic signed [ACC_WIDTH-1:0]  acci_q [NUM_SC];
    logic signed [ACC_WIDTH-1:0]  acci_d [NUM_SC];
    logic signed [ACC_WIDTH-1:0]  accq_q [NUM_SC];
    logic signed [ACC_WIDTH-1:0]  accq_d [NUM_SC];
    logic [31:0]                  lati_q [NUM_SC];
    logic [31:0]                  lati_d [NUM_SC];
    logic [31:0]                  latq_q [NUM_SC];
    logic [31:0]                  latq_d [NUM_SC];

    logic                         accept_c;
    logic                         last_c;
    logic [31:0]                  word_c;

    // Add one sign-extended sample to an accumulator (wrap or clamp).
    function automatic logic signed [ACC_WIDTH-1:0] acc_add(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic signed [15:0]          s
    );
`ifdef SUBCARRIER_INTEGRATOR_SATURATE_EN
        logic signed [ACC_WIDTH:0] sum;
        sum = (ACC_WIDTH + 1)'(a) + (ACC_WIDTH + 1)'(s);
        if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
            if (sum[ACC_WIDTH]) begin
                return {1'b1, {(ACC_WIDTH - 1){1'b0}}};
            end else begin
                return {1'b0, {(ACC_WIDTH - 1){1'b1}}};
            end
        end
        return sum[ACC_WIDTH-1:0];
`else
        return a + ACC_WIDTH'(s);
`endif
    endfunction

    // 32-bit output window starting at OUT_SHIFT.
    function automatic logic [31:0] win(input logic signed [ACC_WIDTH-1:0] a);
`ifdef SUBCARRIER_INTEGRATOR_SATURATE_EN
        logic signed [63:0] ext;
        ext = 64'(a) >>> OUT_SHIFT;
        if (ext > 64'sh0000_0000_7FFF_FFFF) begin
            return 32'h7FFF_FFFF;
        end else if (ext < 64'shFFFF_FFFF_8000_0000) begin
            return 32'h8000_0000;
        end
        return ext[31:0];
`else
        return 32'(64'(a) >>> OUT_SHIFT);
`endif
    endfunction

    assign accept_c = (state_q == ST_SEND) && data_out_strobe;
    assign last_c   = (beat_q == LAST_BEAT);

    // Next-state: accumulation, dwell-end latch/overrun, beat handshake.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        seq_d     = seq_q;
        seq_lat_d = seq_lat_q;
        rec_d     = rec_q;
        rec_lat_d = rec_lat_q;
        ovr_d     = ovr_q;
        acci_d    = acci_q;
        accq_d    = accq_q;
        lati_d    = lati_q;
        latq_d    = latq_q;

        if (freq_step) begin
            for (int k = 0; k < int'(NUM_SC); k++) begin
                acci_d[k] = '0;
                accq_d[k] = '0;
            end
            rec_d = '0;
            seq_d = seq_q + 8'd1;
            if ((state_q == ST_IDLE) || (accept_c && last_c)) begin
                for (int k = 0; k < int'(NUM_SC); k++) begin
                    lati_d[k] = win(acci_q[k]);
                    latq_d[k] = win(accq_q[k]);
                end
                rec_lat_d = rec_q;
                seq_lat_d = seq_q;
                state_d   = ST_SEND;
                beat_d    = '0;
            end else begin
                ovr_d = 1'b1;
                if (accept_c) begin
                    beat_d = beat_q + BW'(1);
                end
            end
        end else begin
            if (record) begin
                for (int k = 0; k < int'(NUM_SC); k++) begin
                    acci_d[k] = acc_add(acci_q[k], bb_i[16*k +: 16]);
                    accq_d[k] = acc_add(accq_q[k], bb_q[16*k +: 16]);
                end
                if (rec_q != 16'hFFFF) begin
                    rec_d = rec_q + 16'd1;
                end
            end
            if (accept_c) begin
                if (last_c) begin
                    state_d = ST_IDLE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            beat_q    <= '0;
            seq_q     <= '0;
            seq_lat_q <= '0;
            rec_q     <= '0;
            rec_lat_q <= '0;
            ovr_q     <= 1'b0;
            for (int k = 0; k < int'(NUM_SC); k++) begin
                acci_q[k] <= '0;
                accq_q[k] <= '0;
                lati_q[k] <= '0;
                latq_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            seq_q     <= seq_d;
            seq_lat_q <= seq_lat_d;
            rec_q     <= rec_d;
            rec_lat_q <= rec_lat_d;
            ovr_q     <= ovr_d;
            acci_q    <= acci_d;
            accq_q    <= accq_d;
            lati_q    <= lati_d;
            latq_q    <= latq_d;
        end
    end

    // Beat mux: selects the presented word from the beat index only.
    always_comb begin
        word_c = 32'h8000_0000;
        if (state_q == ST_SEND) begin
            if (beat_q == '0) begin
                word_c = {16'h7FFE, seq_lat_q, 8'(NUM_SC)};
            end else if (last_c) begin
                word_c = {rec_lat_q, 16'h0000};
            end else begin
                for (int k = 0; k < int'(NUM_SC); k++) begin
                    if (beat_q == BW'(k + 1)) begin
                        word_c = lati_q[k];
                    end
                    if (beat_q == BW'(k + 1 + int'(NUM_SC))) begin
                        word_c = latq_q[k];
                    end
                end
            end
        end
    end

    assign out_valid = (state_q == ST_SEND);
    assign i_out     = word_c[31:16];
    assign q_out     = word_c[15:0];
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_subcarrier_integrator.sv
// Directed bench for subcarrier_integrator: default instance (4 channels)
// plus a narrow single-channel instance (ACC_WIDTH=20, OUT_SHIFT=0).
module tb_subcarrier_integrator;

    localparam int unsigned NSC = 4;

    logic                 clock = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 record = 1'b0;
    logic                 freq_step = 1'b0;
    logic                 strobe = 1'b0;
    logic [16*NSC-1:0]    bb_i = '0;
    logic [16*NSC-1:0]    bb_q = '0;
    logic                 out_valid;
    logic [15:0]          i_out;
    logic [15:0]          q_out;
    logic                 overrun;

    logic                 record20 = 1'b0;
    logic                 fs20 = 1'b0;
    logic                 strobe20 = 1'b0;
    logic [15:0]          bbi20 = '0;
    logic [15:0]          bbq20 = '0;
    logic                 valid20;
    logic [15:0]          i20;
    logic [15:0]          q20;
    logic                 ovr20;

    int checks = 0;
    int failures = 0;

    subcarrier_integrator dut (
        .clock(clock), .reset_n(reset_n), .record(record), .freq_step(freq_step),
        .bb_i(bb_i), .bb_q(bb_q), .data_out_strobe(strobe),
        .out_valid(out_valid), .i_out(i_out), .q_out(q_out), .overrun(overrun)
    );

    subcarrier_integrator #(.NUM_SC(1), .ACC_WIDTH(20), .OUT_SHIFT(0)) dut20 (
        .clock(clock), .reset_n(reset_n), .record(record20), .freq_step(fs20),
        .bb_i(bbi20), .bb_q(bbq20), .data_out_strobe(strobe20),
        .out_valid(valid20), .i_out(i20), .q_out(q20), .overrun(ovr20)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        record = 1'b0; freq_step = 1'b0; strobe = 1'b0;
        record20 = 1'b0; fs20 = 1'b0; strobe20 = 1'b0;
        bb_i = '0; bb_q = '0; bbi20 = '0; bbq20 = '0;
        repeat (3) cyc();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        cyc();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (i_out !== 16'h8000) begin failures++; $display("FAIL reset_i got=%h exp=8000", i_out); end
        checks++; if (q_out !== 16'h0000) begin failures++; $display("FAIL reset_q got=%h exp=0000", q_out); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    endtask

    task automatic test_frame();
        logic [31:0] exp_w;
        do_reset();
        for (int k = 0; k < int'(NSC); k++) begin
            bb_i[16*k +: 16] = 16'(k + 1);
            bb_q[16*k +: 16] = 16'(-(k + 1));
        end
        record = 1'b1;
        repeat (16) cyc();
        record = 1'b0; freq_step = 1'b1;
        cyc();
        freq_step = 1'b0;
        for (int b = 0; b < 10; b++) begin
            if (b == 0)      exp_w = 32'h7FFE_0004;
            else if (b <= 4) exp_w = 32'(b);
            else if (b <= 8) exp_w = 32'(-(b - 4));
            else             exp_w = 32'h0010_0000;
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL frame_valid beat=%0d got=%b exp=1", b, out_valid); end
            checks++; if ({i_out, q_out} !== exp_w) begin failures++; $display("FAIL frame_beat beat=%0d got=%h exp=%h", b, {i_out, q_out}, exp_w); end
            strobe = 1'b1;
            cyc();
            strobe = 1'b0;
        end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL frame_end_valid got=%b exp=0", out_valid); end
        checks++; if ({i_out, q_out} !== 32'h8000_0000) begin failures++; $display("FAIL frame_end_idle got=%h exp=80000000", {i_out, q_out}); end
    endtask

    task automatic test_overrun();
        logic [31:0] exp_w;
        do_reset();
        for (int k = 0; k < int'(NSC); k++) bb_i[16*k +: 16] = 16'h0100;
        record = 1'b1;
        cyc();
        record = 1'b0; freq_step = 1'b1;
        cyc();
        freq_step = 1'b0;
        for (int b = 0; b < 3; b++) begin
            exp_w = (b == 0) ? 32'h7FFE_0004 : 32'h0000_0010;
            checks++; if ({i_out, q_out} !== exp_w) begin failures++; $display("FAIL ovr_pre beat=%0d got=%h exp=%h", b, {i_out, q_out}, exp_w); end
            strobe = 1'b1; cyc(); strobe = 1'b0;
        end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_before got=%b exp=0", overrun); end
        freq_step = 1'b1;
        cyc();
        freq_step = 1'b0;
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", overrun); end
        for (int b = 3; b < 10; b++) begin
            if (b <= 4)      exp_w = 32'h0000_0010;
            else if (b <= 8) exp_w = 32'h0000_0000;
            else             exp_w = 32'h0001_0000;
            checks++; if ({i_out, q_out} !== exp_w) begin failures++; $display("FAIL ovr_rest beat=%0d got=%h exp=%h", b, {i_out, q_out}, exp_w); end
            strobe = 1'b1; cyc(); strobe = 1'b0;
        end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ovr_end_valid got=%b exp=0", out_valid); end
        freq_step = 1'b1;
        cyc();
        freq_step = 1'b0;
        checks++; if ({i_out, q_out} !== 32'h7FFE_0204) begin failures++; $display("FAIL ovr_next_hdr got=%h exp=7ffe0204", {i_out, q_out}); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w;
        do_reset();
        for (int k = 0; k < int'(NSC); k++) begin
            bb_i[16*k +: 16] = 16'h0010;
            bb_q[16*k +: 16] = 16'hFFF0;
        end
        record = 1'b1;
        repeat (2) cyc();
        record = 1'b0; freq_step = 1'b1;
        cyc();
        freq_step = 1'b0;
        for (int b = 0; b < 9; b++) begin
            if (b == 0)      exp_w = 32'h7FFE_0004;
            else if (b <= 4) exp_w = 32'h0000_0002;
            else             exp_w = 32'hFFFF_FFFE;
            checks++; if ({i_out, q_out} !== exp_w) begin failures++; $display("FAIL b2b_f0 beat=%0d got=%h exp=%h", b, {i_out, q_out}, exp_w); end
            record = 1'b1; strobe = 1'b1;
            cyc();
        end
        record = 1'b0;
        checks++; if ({i_out, q_out} !== 32'h0002_0000) begin failures++; $display("FAIL b2b_f0_last got=%h exp=00020000", {i_out, q_out}); end
        freq_step = 1'b1; strobe = 1'b1;
        cyc();
        freq_step = 1'b0; strobe = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", out_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
        checks++; if ({i_out, q_out} !== 32'h7FFE_0104) begin failures++; $display("FAIL b2b_hdr got=%h exp=7ffe0104", {i_out, q_out}); end
        for (int b = 1; b < 10; b++) begin
            strobe = 1'b1; cyc(); strobe = 1'b0;
            if (b <= 4)      exp_w = 32'h0000_0009;
            else if (b <= 8) exp_w = 32'hFFFF_FFF7;
            else             exp_w = 32'h0009_0000;
            checks++; if ({i_out, q_out} !== exp_w) begin failures++; $display("FAIL b2b_f1 beat=%0d got=%h exp=%h", b, {i_out, q_out}, exp_w); end
        end
    endtask

    task automatic test_window();
        logic [31:0] exp_b1;
`ifdef SUBCARRIER_INTEGRATOR_SATURATE_EN
        exp_b1 = 32'h0007_FFFF;
`else
        exp_b1 = 32'h0003_FFD8;
`endif
        do_reset();
        bbi20 = 16'h7FFF;
        record20 = 1'b1;
        repeat (40) cyc();
        record20 = 1'b0; fs20 = 1'b1;
        cyc();
        fs20 = 1'b0;
        checks++; if ({i20, q20} !== 32'h7FFE_0001) begin failures++; $display("FAIL win_hdr got=%h exp=7ffe0001", {i20, q20}); end
        strobe20 = 1'b1; cyc(); strobe20 = 1'b0;
        checks++; if ({i20, q20} !== exp_b1) begin failures++; $display("FAIL win_i got=%h exp=%h", {i20, q20}, exp_b1); end
        strobe20 = 1'b1; cyc(); strobe20 = 1'b0;
        checks++; if ({i20, q20} !== 32'h0000_0000) begin failures++; $display("FAIL win_q got=%h exp=00000000", {i20, q20}); end
        strobe20 = 1'b1; cyc(); strobe20 = 1'b0;
        checks++; if ({i20, q20} !== 32'h0028_0000) begin failures++; $display("FAIL win_rec got=%h exp=00280000", {i20, q20}); end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        for (int k = 0; k < int'(NSC); k++) bb_i[16*k +: 16] = 16'h0100;
        record = 1'b1;
        cyc();
        record = 1'b0; freq_step = 1'b1;
        cyc();
        freq_step = 1'b0;
        repeat (5) begin strobe = 1'b1; cyc(); end
        strobe = 1'b0;
        checks++; if ({i_out, q_out} !== 32'h0000_0000) begin failures++; $display("FAIL mid_beat5 got=%h exp=00000000", {i_out, q_out}); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_valid got=%b exp=1", out_valid); end
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
        checks++; if ({i_out, q_out} !== 32'h8000_0000) begin failures++; $display("FAIL mid_rst_idle got=%h exp=80000000", {i_out, q_out}); end
        strobe = 1'b1;
        repeat (2) cyc();
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_post_valid cyc=%0d got=%b exp=0", c, out_valid); end
        end
        strobe = 1'b0; freq_step = 1'b1;
        cyc();
        freq_step = 1'b0;
        checks++; if ({i_out, q_out} !== 32'h7FFE_0004) begin failures++; $display("FAIL mid_new_hdr got=%h exp=7ffe0004", {i_out, q_out}); end
        strobe = 1'b1; cyc(); strobe = 1'b0;
        checks++; if ({i_out, q_out} !== 32'h0000_0000) begin failures++; $display("FAIL mid_new_b1 got=%h exp=00000000", {i_out, q_out}); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_overrun();
        test_back_to_back();
        test_window();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
